// File: rtl/lift_scale_shoup_pkg.sv
// Shared constants, FSM state type and coefficient ROM contents for the lift scaler.
package lift_pkg;
   localparam int W             = 30;
   localparam int N_SMALL       = 6;
   localparam int N_BIG         = 7;
   localparam int SUM_START_LEN = 7;

   localparam logic [W-1:0] ROM_Q  = W'((64'd1 << W) - 64'd35);
   localparam logic [W-1:0] ROM_W  = W'(5);
   localparam logic [W-1:0] ROM_WP = W'((64'(ROM_W) << W) / 64'(ROM_Q));

   typedef enum logic [1:0] {IDLE, LOAD, DRAIN, KICK} state_t;

   // addr = {mode, 2'b00, i}; unused slots (incl. small-mode slot 6) read as zero
   function automatic logic [3*W-1:0] rom_entry(input logic [5:0] addr);
      logic [3*W-1:0] d;
      d = '0;
      if (addr[4:3] == 2'b00 &&
          (addr[5] ? (addr[2:0] < 3'(N_BIG)) : (addr[2:0] < 3'(N_SMALL))))
         d = {ROM_Q, ROM_W, ROM_WP};
      return d;
   endfunction
endpackage

// File: rtl/lift_scale_shoup_if.sv
// Residue input handshake, share RAM write port and sum-stage control of the lift scaler.
interface lift_scale_shoup_if;
   import lift_pkg::*;
   logic         mode;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic [2:0]   ext_addr;
   logic         ext_we;
   logic [W-1:0] ext_din;
   logic         sum_start;
   logic         busy;
   logic         range_err;
   state_t       dbg_state;

   // A residue moves when in_valid & in_ready are both high on a rising clk edge.
   modport master (output mode, in_valid, in_data,
                   input  in_ready, ext_addr, ext_we, ext_din, sum_start, busy, range_err, dbg_state);
   modport slave  (input  mode, in_valid, in_data,
                   output in_ready, ext_addr, ext_we, ext_din, sum_start, busy, range_err, dbg_state);
endinterface

// File: rtl/lift_scale_shoup_rom.sv
// Registered-read constant ROM holding {q, w, wp} per {mode, index}.
module lift_scale_rom
   import lift_pkg::*;
(
   input  logic           i_clk,
   input  logic [5:0]     i_addr,
   output logic [3*W-1:0] o_data
);
   logic [3*W-1:0] r_data;

   always_ff @(posedge i_clk) r_data <= rom_entry(i_addr);

   assign o_data = r_data;
endmodule

// File: rtl/lift_scale_shoup.sv
// Shoup modular scaler feeding the lift sum stage; optional input range check under LIFT_SCALE_RANGE_CHECK_EN.
module lift_scale_shoup
   import lift_pkg::*;
#(
   parameter int MUL_LAT = 3
)(
   input logic               clk,
   input logic               rst,
   lift_scale_shoup_if.slave bus
);
   localparam int LAST = MUL_LAT - 1;

   state_t     r_state;
   logic       r_mode, r_sum_start, r_busy;
   logic [2:0] r_cnt, r_kick_cnt;
   logic       w_mode, w_in_ready, w_xfer, w_inject, w_pipe_busy;
   logic [2:0] w_n, w_idx;

   assign w_mode     = (r_state == IDLE) ? bus.mode : r_mode;
   assign w_n        = r_mode ? 3'(N_BIG) : 3'(N_SMALL);
   assign w_in_ready = (r_state == IDLE) || (r_state == LOAD && r_cnt < w_n);
   assign w_xfer     = bus.in_valid && w_in_ready;
   // Small blocks push a zero share into slot 6 right after the last residue
   assign w_inject   = (r_state == LOAD) && (r_cnt == w_n) && !r_mode;
   assign w_idx      = w_inject ? 3'd6 : ((r_state == IDLE) ? 3'd0 : r_cnt);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE; r_mode <= 1'b0; r_cnt <= 3'd0; r_kick_cnt <= 3'd0;
         r_sum_start <= 1'b0; r_busy <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (w_xfer) begin
               r_state <= LOAD; r_mode <= bus.mode; r_cnt <= 3'd1; r_busy <= 1'b1;
            end
            LOAD: if (w_xfer) r_cnt <= r_cnt + 3'd1;
                  else if (r_cnt == w_n) r_state <= DRAIN;
            DRAIN: if (!w_pipe_busy) begin
               r_state <= KICK; r_sum_start <= 1'b1; r_kick_cnt <= 3'd0;
            end
            KICK: if (r_kick_cnt == 3'(SUM_START_LEN - 1)) begin
               r_state <= IDLE; r_sum_start <= 1'b0; r_busy <= 1'b0; r_cnt <= 3'd0;
            end else r_kick_cnt <= r_kick_cnt + 3'd1;
            default: r_state <= IDLE;
         endcase
      end
   end

   logic [3*W-1:0] w_rom_data;
   logic [W-1:0]   w_rom_q, w_rom_w, w_rom_wp;

   lift_scale_rom u_rom (.i_clk(clk), .i_addr({w_mode, 2'b00, w_idx}), .o_data(w_rom_data));
   assign {w_rom_q, w_rom_w, w_rom_wp} = w_rom_data;

   logic               r_s0_v, r_c_v, r_ext_we;
   logic [MUL_LAT-1:0] r_m1_v, r_m2_v;
   logic [2:0]         r_s0_addr, r_c_addr, r_ext_addr;
   logic [W-1:0]       r_s0_a, r_c_q, r_ext_din;
   logic [W+1:0]       r_c_r;
   logic [2:0]         r_m1_addr [MUL_LAT], r_m2_addr [MUL_LAT];
   logic [W-1:0]       r_m1_q [MUL_LAT], r_m1_h [MUL_LAT], r_m2_q [MUL_LAT];
   logic [2*W-1:0]     r_m1_p [MUL_LAT], r_m2_p [MUL_LAT], r_m2_hq [MUL_LAT];

   assign w_pipe_busy = r_s0_v || (|r_m1_v) || (|r_m2_v) || r_c_v;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s0_v <= 1'b0; r_m1_v <= '0; r_m2_v <= '0; r_c_v <= 1'b0;
         r_ext_we <= 1'b0; r_ext_addr <= 3'd0; r_ext_din <= '0;
      end else begin
         r_s0_v    <= w_xfer || w_inject;
         r_m1_v[0] <= r_s0_v;
         r_m2_v[0] <= r_m1_v[LAST];
         for (int k = 1; k < MUL_LAT; k++) begin
            r_m1_v[k] <= r_m1_v[k-1];
            r_m2_v[k] <= r_m2_v[k-1];
         end
         r_c_v    <= r_m2_v[LAST];
         r_ext_we <= r_c_v;
         if (r_c_v) begin
            r_ext_addr <= r_c_addr;
            r_ext_din  <= (r_c_r >= {2'b00, r_c_q}) ? W'(r_c_r - {2'b00, r_c_q}) : W'(r_c_r);
         end
      end
   end

   // Data lanes carry no reset; the valid bits above qualify them
   always_ff @(posedge clk) begin
      r_s0_a       <= w_xfer ? bus.in_data : '0;
      r_s0_addr    <= w_idx;
      r_m1_p[0]    <= (2*W)'(r_s0_a) * (2*W)'(w_rom_w);
      r_m1_h[0]    <= W'(((2*W)'(r_s0_a) * (2*W)'(w_rom_wp)) >> W);
      r_m1_q[0]    <= w_rom_q;
      r_m1_addr[0] <= r_s0_addr;
      r_m2_hq[0]   <= (2*W)'(r_m1_h[LAST]) * (2*W)'(r_m1_q[LAST]);
      r_m2_p[0]    <= r_m1_p[LAST];
      r_m2_q[0]    <= r_m1_q[LAST];
      r_m2_addr[0] <= r_m1_addr[LAST];
      for (int k = 1; k < MUL_LAT; k++) begin
         r_m1_p[k] <= r_m1_p[k-1]; r_m1_h[k] <= r_m1_h[k-1];
         r_m1_q[k] <= r_m1_q[k-1]; r_m1_addr[k] <= r_m1_addr[k-1];
         r_m2_hq[k] <= r_m2_hq[k-1]; r_m2_p[k] <= r_m2_p[k-1];
         r_m2_q[k] <= r_m2_q[k-1]; r_m2_addr[k] <= r_m2_addr[k-1];
      end
      // Remainder lies in [0, 2q), so W+2 bits of the difference are exact
      r_c_r    <= (W+2)'(r_m2_p[LAST] - r_m2_hq[LAST]);
      r_c_q    <= r_m2_q[LAST];
      r_c_addr <= r_m2_addr[LAST];
   end

`ifdef LIFT_SCALE_RANGE_CHECK_EN
   logic r_s0_chk, r_range_err;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s0_chk <= 1'b0; r_range_err <= 1'b0;
      end else begin
         r_s0_chk <= w_xfer;
         if (r_s0_chk && r_s0_a >= w_rom_q) r_range_err <= 1'b1;
      end
   end
   assign bus.range_err = r_range_err;
`else
   assign bus.range_err = 1'b0;
`endif

   assign bus.in_ready  = w_in_ready;
   assign bus.ext_we    = r_ext_we;
   assign bus.ext_addr  = r_ext_addr;
   assign bus.ext_din   = r_ext_din;
   assign bus.sum_start = r_sum_start;
   assign bus.busy      = r_busy;
   assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_lift_scale_shoup.sv
// Directed bench for lift_scale_shoup: scoreboard of share writes plus handshake/kick/reset checks.
module tb_lift_scale_shoup;
   import lift_pkg::*;

   localparam logic [W-1:0] Q_T = 30'd1073741789;
   localparam logic [W-1:0] W_T = 30'd5;
   localparam int           L_T = 9;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0, n_fail = 0;
   int   cyc_n = 0, last_xfer = 0, first_we = -1, last_we = -1;
   logic exp_re;
   logic [W+2:0] exp_q[$];

   lift_scale_shoup_if bus();
   lift_scale_shoup #(.MUL_LAT(3)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;
   always @(posedge clk) cyc_n <= cyc_n + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [W-1:0] model(input logic [W-1:0] a);
      return W'((64'(a) * 64'(W_T)) % 64'(Q_T));
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && bus.ext_we) begin
         logic [W+2:0] e;
         if (first_we < 0) first_we = cyc_n;
         last_we = cyc_n;
         chk("write_expected", 64'(exp_q.size() > 0), 64'd1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("wr_addr", 64'(bus.ext_addr), 64'(e[W+2:W]));
            chk("wr_data", 64'(bus.ext_din), 64'(e[W-1:0]));
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic xfer(input logic m, input logic [2:0] idx, input logic [W-1:0] a);
      int t = 0;
      bus.mode = m; bus.in_data = a; bus.in_valid = 1'b1;
      while (!bus.in_ready && t < 50) begin cyc(1); t++; end
      chk("in_ready_wait", 64'(t < 50), 64'd1);
      exp_q.push_back({idx, model(a)});
      cyc(1);
      last_xfer = cyc_n - 1;
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_kick();
      int t = 0, len = 0;
      @(negedge clk);
      while (!bus.sum_start && t < 200) begin @(negedge clk); t++; end
      chk("kick_timeout", 64'(t < 200), 64'd1);
      chk("writes_done_at_kick", 64'(exp_q.size()), 64'd0);
      while (bus.sum_start && len < 20) begin
         chk("busy_in_kick", 64'(bus.busy), 64'd1);
         len++;
         @(negedge clk);
      end
      chk("sum_start_len", 64'(len), 64'(SUM_START_LEN));
      @(negedge clk);
      chk("busy_after_kick", 64'(bus.busy), 64'd0);
      chk("ready_after_kick", 64'(bus.in_ready), 64'd1);
      cyc(1);
   endtask

   initial begin
`ifdef LIFT_SCALE_RANGE_CHECK_EN
      exp_re = 1'b1;
`else
      exp_re = 1'b0;
`endif
      bus.mode = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;

      // 1: reset values, then idle
      cyc(3);
      chk("rst_ext_we", 64'(bus.ext_we), 64'd0);
      chk("rst_ext_addr", 64'(bus.ext_addr), 64'd0);
      chk("rst_ext_din", 64'(bus.ext_din), 64'd0);
      chk("rst_sum_start", 64'(bus.sum_start), 64'd0);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
      chk("rst_range_err", 64'(bus.range_err), 64'd0);
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("idle_ext_we", 64'(bus.ext_we), 64'd0);
         chk("idle_sum_start", 64'(bus.sum_start), 64'd0);
         chk("idle_busy", 64'(bus.busy), 64'd0);
         chk("idle_in_ready", 64'(bus.in_ready), 64'd1);
      end
      cyc(1);

      // 2: small block back-to-back, filler write to slot 6
      first_we = -1;
      for (int i = 0; i < 6; i++) xfer(1'b0, 3'(i), W'(i));
      chk("small_full_ready", 64'(bus.in_ready), 64'd0);
      exp_q.push_back({3'd6, {W{1'b0}}});
      wait_kick();
      chk("small_write_span", 64'(last_we - first_we), 64'd6);

      // 3: big block at a = q-1, latency of first write
      first_we = -1;
      xfer(1'b1, 3'd0, Q_T - 1);
      begin
         int t0;
         t0 = last_xfer;
         chk("busy_after_accept", 64'(bus.busy), 64'd1);
         for (int i = 1; i < 7; i++) xfer(1'b1, 3'(i), Q_T - 1);
         wait_kick();
         chk("latency", 64'(first_we - t0), 64'(L_T));
      end

      // 4: big block with gaps and mode toggling mid-block
      for (int i = 0; i < 7; i++) begin
         xfer((i == 0) ? 1'b1 : 1'($urandom_range(1, 0)), 3'(i), W'($urandom_range(Q_T - 1, 0)));
         cyc($urandom_range(3, 0));
      end
      bus.in_valid = 1'b1; bus.in_data = 30'd123;
      for (int i = 0; i < 3; i++) begin
         chk("big_full_ready", 64'(bus.in_ready), 64'd0);
         cyc(1);
      end
      bus.in_valid = 1'b0;
      wait_kick();

      // 5: reset while draining, then a fresh block
      for (int i = 0; i < 7; i++) xfer(1'b1, 3'(i), W'(1000 * i + 3));
      begin
         int t = 0;
         while (bus.dbg_state != DRAIN && t < 50) begin cyc(1); t++; end
         chk("reach_drain", 64'(t < 50), 64'd1);
      end
      rst = 1'b1;
      cyc(1);
      chk("rstd_ext_we", 64'(bus.ext_we), 64'd0);
      chk("rstd_sum_start", 64'(bus.sum_start), 64'd0);
      chk("rstd_busy", 64'(bus.busy), 64'd0);
      rst = 1'b0;
      exp_q.delete();
      for (int i = 0; i < 6; i++) xfer(1'b0, 3'(i), W'($urandom_range(Q_T - 1, 0)));
      exp_q.push_back({3'd6, {W{1'b0}}});
      wait_kick();

      // reset during the kick window
      for (int i = 0; i < 6; i++) xfer(1'b0, 3'(i), W'(7 * i));
      exp_q.push_back({3'd6, {W{1'b0}}});
      begin
         int t = 0;
         while (!bus.sum_start && t < 100) begin cyc(1); t++; end
         chk("reach_kick", 64'(t < 100), 64'd1);
      end
      rst = 1'b1;
      cyc(1);
      chk("rstk_sum_start", 64'(bus.sum_start), 64'd0);
      chk("rstk_ready", 64'(bus.in_ready), 64'd1);
      rst = 1'b0;
      exp_q.delete();

      // 6: out-of-range residue a_3 = q_3
      chk("re_before", 64'(bus.range_err), 64'd0);
      for (int i = 0; i < 7; i++) xfer(1'b1, 3'(i), (i == 3) ? Q_T : W'(1000 * i));
      wait_kick();
      chk("re_raised", 64'(bus.range_err), 64'(exp_re));
      for (int i = 0; i < 6; i++) xfer(1'b0, 3'(i), W'(i + 11));
      exp_q.push_back({3'd6, {W{1'b0}}});
      wait_kick();
      chk("re_sticky", 64'(bus.range_err), 64'(exp_re));
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      chk("re_cleared", 64'(bus.range_err), 64'd0);
      cyc(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
